// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of a small gate: drive every input vector, hold SETTLE+1 cycles, sample Y, compare.
// Optional SWEEP_GRAY_EN: drive vectors in Gray-code order (single-bit toggles), results still indexed by binary value.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [(1 << N_IN) - 1:0]  expected,
  output logic [N_IN - 1:0]         dut_in,
  input  logic                      dut_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [(1 << N_IN) - 1:0]  captured,
  output logic [N_IN:0]             mismatch_cnt
);

  localparam int TT_W = 1 << N_IN;
  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [N_IN:0] IDX_LAST = (N_IN + 1)'(TT_W - 1);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, REPORT} state_t;

  state_t            state_q, state_d;
  logic [N_IN:0]     idx_q, idx_d;
  logic [3:0]        scnt_q, scnt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   cap_q, cap_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     mm_q, mm_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;

  logic [N_IN-1:0]   nxt_bin;
  logic [N_IN-1:0]   nxt_vec;
  logic [TT_W-1:0]   diff;
  logic [N_IN:0]     pcnt;

  always_comb begin
    nxt_bin = idx_q[N_IN-1:0] + N_IN'(1);
`ifdef SWEEP_GRAY_EN
    nxt_vec = nxt_bin ^ (nxt_bin >> 1);
`else
    nxt_vec = nxt_bin;
`endif
  end

  always_comb begin
    diff = cap_q ^ exp_q;
    pcnt = '0;
    for (int i = 0; i < TT_W; i++) begin
      pcnt = pcnt + (N_IN + 1)'(diff[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    exp_d    = exp_q;
    cap_d    = cap_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    dut_in_d = dut_in_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d    = expected;
          idx_d    = '0;
          dut_in_d = '0;
          scnt_d   = SETTLE_V;
          cap_d    = '0;
          pass_d   = 1'b0;
          mm_d     = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (scnt_q != 4'd0) begin
          scnt_d = scnt_q - 4'd1;
        end else begin
          // The driven vector is the binary index of its table entry in either order.
          cap_d[dut_in_q] = dut_out;
          if (idx_q == IDX_LAST) begin
            state_d = CHECK;
          end else begin
            idx_d    = idx_q + (N_IN + 1)'(1);
            dut_in_d = nxt_vec;
            scnt_d   = SETTLE_V;
          end
        end
      end
      CHECK: begin
        mm_d    = pcnt;
        pass_d  = (pcnt == '0);
        state_d = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      scnt_q   <= '0;
      exp_q    <= '0;
      cap_q    <= '0;
      pass_q   <= 1'b0;
      mm_q     <= '0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      exp_q    <= exp_d;
      cap_q    <= cap_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == REPORT);
  assign pass         = pass_q;
  assign captured     = cap_q;
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: u0 uses SETTLE=1, u1 uses SETTLE=0, both with N_IN=2 and a behavioural gate.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [3:0] exp0, exp1;
  logic [1:0] g0, g1;
  logic [1:0] din0, din1;
  logic       y0, y1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] cap0, cap1;
  logic [2:0] mm0, mm1;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .dut_in(din0),
    .dut_out(y0), .busy(busy0), .done(done0), .pass(pass0), .captured(cap0),
    .mismatch_cnt(mm0)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .dut_in(din1),
    .dut_out(y1), .busy(busy1), .done(done1), .pass(pass1), .captured(cap1),
    .mismatch_cnt(mm1)
  );

  // gate select: 0 XOR, 1 AND, 2 NAND, 3 OR; v[1] is A, v[0] is B
  function automatic logic gate_y(input logic [1:0] g, input logic [1:0] v);
    case (g)
      2'd0:    return v[1] ^ v[0];
      2'd1:    return v[1] & v[0];
      2'd2:    return ~(v[1] & v[0]);
      default: return v[1] | v[0];
    endcase
  endfunction

  assign y0 = gate_y(g0, din0);
  assign y1 = gate_y(g1, din1);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0] gate;
    logic [3:0] expd;
    logic [3:0] cap;
    logic       pass;
    int         mm;
  } vec_t;

  vec_t tbl[4];
  int   order[4];

  task automatic tick0;
    @(posedge clk);
    #1;
  endtask

  // Full sweep on u0; cycle 1 is the cycle right after the accepting edge.
  task automatic run0(input string nm, input logic [1:0] g, input logic [3:0] e,
                      input logic [3:0] ecap, input logic ep, input int emm);
    int cyc;
    int seq_err;
    @(negedge clk);
    g0 = g; exp0 = e; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    exp0   = ~e;
    cyc = 1;
    seq_err = 0;
    while (!done0 && cyc < 40) begin
      if (cyc <= 8 && int'(din0) != order[(cyc - 1) / 2]) seq_err++;
      if (!busy0) seq_err++;
      tick0();
      cyc++;
    end
    chk({nm, " latency"}, cyc, 10);
    chk({nm, " dut_in seq"}, seq_err, 0);
    chk({nm, " captured"}, cap0, ecap);
    chk({nm, " pass"}, pass0, ep);
    chk({nm, " mismatch_cnt"}, mm0, emm);
    tick0();
    chk({nm, " done pulse width"}, done0, 0);
    chk({nm, " busy after"}, busy0, 0);
    chk({nm, " pass held"}, pass0, ep);
    chk({nm, " dut_in held"}, din0, order[3]);
  endtask

  initial begin
    int cyc;
    int seen;
    int seq_err;

`ifdef SWEEP_GRAY_EN
    order = '{0, 1, 3, 2};
`else
    order = '{0, 1, 2, 3};
`endif
    tbl[0] = '{gate: 2'd0, expd: 4'b0110, cap: 4'b0110, pass: 1'b1, mm: 0};
    tbl[1] = '{gate: 2'd1, expd: 4'b0110, cap: 4'b1000, pass: 1'b0, mm: 3};
    tbl[2] = '{gate: 2'd2, expd: 4'b0111, cap: 4'b0111, pass: 1'b1, mm: 0};
    tbl[3] = '{gate: 2'd3, expd: 4'b1111, cap: 4'b1110, pass: 1'b0, mm: 1};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    exp0 = '0; exp1 = '0; g0 = '0; g1 = '0;
    #1;
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset dut_in", din0, 0);
    chk("reset captured", cap0, 0);
    chk("reset mm", mm0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick0();

    for (int i = 0; i < 4; i++) begin
      run0($sformatf("vec%0d", i), tbl[i].gate, tbl[i].expd, tbl[i].cap, tbl[i].pass, tbl[i].mm);
    end

    // start held high for the whole sweep and beyond
    @(negedge clk);
    g0 = 2'd0; exp0 = 4'b0110; start0 = 1'b1;
    tick0();
    cyc = 1;
    while (!done0 && cyc < 40) begin
      tick0();
      cyc++;
    end
    chk("held latency", cyc, 10);
    chk("held pass", pass0, 1);
    chk("held captured", cap0, 4'b0110);
    tick0();
    chk("held idle gap busy", busy0, 0);
    chk("held idle gap pass", pass0, 1);
    g0 = 2'd1;
    tick0();
    chk("held restart busy", busy0, 1);
    chk("held restart captured clr", cap0, 0);
    chk("held restart pass clr", pass0, 0);
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 40) begin
      tick0();
      cyc++;
    end
    chk("second latency", cyc, 10);
    chk("second captured", cap0, 4'b1000);
    chk("second mm", mm0, 3);
    tick0();

    // async reset at idx 2
    @(negedge clk);
    g0 = 2'd0; exp0 = 4'b0110; start0 = 1'b1;
    tick0();
    start0 = 1'b0;
    repeat (4) tick0();
    chk("rst pre dut_in", din0, order[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("rst dut_in", din0, 0);
    chk("rst busy", busy0, 0);
    chk("rst captured", cap0, 0);
    chk("rst pass", pass0, 0);
    seen = 0;
    repeat (12) begin
      tick0();
      if (done0) seen++;
    end
    chk("rst no done", seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run0("post rst", 2'd0, 4'b0110, 4'b0110, 1'b1, 0);

    // SETTLE=0 instance
    @(negedge clk);
    g1 = 2'd0; exp1 = 4'b0110; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    cyc = 1;
    seq_err = 0;
    while (!done1 && cyc < 40) begin
      if (cyc <= 4 && int'(din1) != order[cyc - 1]) seq_err++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("s0 latency", cyc, 6);
    chk("s0 dut_in seq", seq_err, 0);
    chk("s0 captured", cap1, 4'b0110);
    chk("s0 pass", pass1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Exhaustive truth-table sequencer for the small combinational gate blocks (2-input A/B -> Y problems).
- Steps the gate's input vector through every combination and holds each one for a programmable settle time.
- Samples Y for each combination into a captured truth table, then compares it against a latched expected table.
- Sits between the gate under check and a host or self-check wrapper, replacing the hand-written A/B stimulus sequence.

Parameters:
N_IN, 2, number of gate inputs; legal range 1..4.
SETTLE, 1, extra cycles each input vector is held before sampling; legal range 0..15.
TT_W, 2**N_IN, truth-table width (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; accepted only in IDLE
expected  input  TT_W  expected table, bit i = Y when dut_in==i; latched on start acceptance
dut_in  output  N_IN  drive to gate inputs; MSB = A, LSB = B for N_IN=2
dut_out  input  1  gate output Y
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse when results are valid
pass  output  1  captured == expected; valid from done, held until next start acceptance
captured  output  TT_W  sampled table, bit i = Y for input vector i
mismatch_cnt  output  N_IN+1  popcount(captured ^ expected)

Behaviour:
Reset (async, immediate on rst_n low):
- State IDLE; dut_in=0, busy=0, done=0, pass=0, captured=0, mismatch_cnt=0; internal index and settle counter =0.
- Reset asserted mid-sweep aborts the sweep: no done pulse, no partial results retained.

FSM states: IDLE, HOLD, CHECK, REPORT.

IDLE:
- On start=1: latch expected, idx<=0, dut_in<=0, scnt<=SETTLE, clear captured/pass/mismatch_cnt, go to HOLD.
- start while not IDLE is ignored; it is neither queued nor restarted.

HOLD:
- While scnt!=0: scnt decrements.
- When scnt==0: captured[idx]<=dut_out.
  - If idx==TT_W-1: go to CHECK.
  - Else: idx++, dut_in<=next vector, scnt<=SETTLE.
- Each vector is driven for exactly SETTLE+1 cycles; the sample is taken at the edge ending the last cycle.

CHECK (1 cycle):
- mismatch_cnt<=popcount(captured^expected_latched); pass<=(mismatch_cnt result==0).

REPORT (1 cycle):
- done=1, then return to IDLE.
- dut_in holds the last vector in IDLE until the next start.

Timing:
- busy=1 in HOLD, CHECK and REPORT.
- Latency from start acceptance edge to done high = TT_W*(SETTLE+1)+2 cycles; for N_IN=2, SETTLE=1 that is 10.
- start asserted in the REPORT cycle is ignored. start in the first IDLE cycle after REPORT is accepted, giving back-to-back sweeps.

Arithmetic and width:
- idx is N_IN+1 bits internally so the terminal compare never wraps.
- Popcount result fits N_IN+1 bits (max TT_W).
- expected changes after acceptance have no effect.

Optional Feature:
Macro SWEEP_GRAY_EN.
- Defined: input vectors are driven in Gray-code order (for N_IN=2: 00,01,11,10). Each sample is stored at captured[binary value of the driven vector], so captured/pass/mismatch_cnt semantics are unchanged; only one dut_in bit toggles per step. Latency is unchanged.
- Undefined: vectors are driven in ascending binary order 0..TT_W-1.

Test Plan:
- N_IN=2, SETTLE=1, gate=XOR, expected=4'b0110, start pulse -> dut_in sequence 00,01,10,11 (2 cycles each); done at cycle 10; captured=0110, pass=1, mismatch_cnt=0.
- Gate=AND, expected=4'b0110 (wrong) -> captured=1000, pass=0, mismatch_cnt=3; done still a single one-cycle pulse.
- start held high across whole sweep, plus extra pulses mid-sweep -> exactly one sweep until REPORT; a second sweep starts in the first IDLE cycle (busy low for 1 cycle) and results are cleared on acceptance.
- rst_n pulled low in HOLD at idx=2 -> all outputs 0 asynchronously, no done; a new start after release gives a full correct sweep.
- SETTLE=0 with XOR -> each vector held 1 cycle, done at cycle 6, captured=0110.
- With SWEEP_GRAY_EN, gate=NAND, expected=4'b0111 -> dut_in order 00,01,11,10; captured=0111, pass=1.
